// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine controller.
// Credit and prices are counted in nickels.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        PAYOUT
    } state_t;

    localparam logic [1:0] NICKEL = 2'd1;
    localparam logic [1:0] DIME   = 2'd2;

    localparam logic [1:0] ITEM0     = 2'd0;
    localparam logic [1:0] ITEM1     = 2'd1;
    localparam logic [1:0] ITEM2     = 2'd2;
    localparam logic [1:0] ITEM_NONE = 2'd3;

    function automatic logic [2:0] price_of(
        input logic [1:0] item,
        input logic [2:0] p0,
        input logic [2:0] p1,
        input logic [2:0] p2
    );
        unique case (item)
            ITEM0:   return p0;
            ITEM1:   return p1;
            ITEM2:   return p2;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// Keypad/coin side and dispenser/coin-return side of the controller.
// The controller is the slave; the machine front panel is the master.
interface vend_if;
    logic       nickel_in;
    logic       dime_in;
    logic [1:0] item_sel;
    logic       sel_valid;
    logic       cancel;
    logic       restock;
    logic       dispense;
    logic [1:0] item_out;
    logic       nickel_out;
    logic       coin_reject;
    logic       sel_err;
    logic [2:0] credit;
    logic [2:0] sold_out;
    logic       busy;

    modport master (
        output nickel_in, dime_in, item_sel, sel_valid, cancel, restock,
        input  dispense, item_out, nickel_out, coin_reject, sel_err,
        input  credit, sold_out, busy
    );

    modport slave (
        input  nickel_in, dime_in, item_sel, sel_valid, cancel, restock,
        output dispense, item_out, nickel_out, coin_reject, sel_err,
        output credit, sold_out, busy
    );
endinterface

// File: rtl/vend_change_pulser.sv
// Pays out a loaded nickel count as pulse, gap, pulse, ...
// fire marks the cycle whose edge raises nickel_out.
module vend_change_pulser #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_cnt,
    output logic          nickel_out,
    output logic          fire,
    output logic          done
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          gap_q, gap_d;
    logic          pulse_q, pulse_d;

    assign fire       = (cnt_q != '0) && !gap_q;
    assign done       = (cnt_q == '0);
    assign nickel_out = pulse_q;

    always_comb begin
        cnt_d   = cnt_q;
        gap_d   = 1'b0;
        pulse_d = fire;
        if (load) begin
            cnt_d = load_cnt;
        end else if (fire) begin
            cnt_d = cnt_q - CW'(1);
            gap_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Coin credit, selection, dispense and change/refund control
// for a three-item vending machine with per-item stock.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 5,
    parameter int MAX_CREDIT = 6,
    parameter int STOCK_INIT = 4,
    parameter int STOCK_W    = 4
) (
    input logic   clock,
    input logic   reset,
    vend_if.slave bus
);

    state_t                    state_q, state_d;
    logic [2:0]                credit_q, credit_d;
    logic [2:0][STOCK_W-1:0]   stock_q, stock_d;
    logic [2:0]                sold_out_q, sold_out_d;
    logic                      dispense_q, dispense_d;
    logic [1:0]                item_out_q, item_out_d;
    logic                      coin_reject_q, coin_reject_d;
    logic                      sel_err_q, sel_err_d;
    logic                      busy_q, busy_d;

    logic                      load, fire, done, nickel_out;
    logic [3:0]                coin_val, coin_sum;
    logic                      coin_any, coin_ok;
    logic [2:0]                price;
    logic [STOCK_W-1:0]        sel_stock;
    logic                      sel_ok;

    always_comb begin
        coin_val = 4'(bus.nickel_in ? NICKEL : 2'd0)
                 + 4'(bus.dime_in ? DIME : 2'd0);
        coin_any = bus.nickel_in | bus.dime_in;
        coin_sum = {1'b0, credit_q} + coin_val;
        price    = price_of(bus.item_sel, 3'(PRICE0),
                            3'(PRICE1), 3'(PRICE2));
        sel_stock = '0;
        for (int i = 0; i < 3; i++)
            if (bus.item_sel == 2'(i)) sel_stock = stock_q[i];
        sel_ok = (bus.item_sel != ITEM_NONE) && (sel_stock != '0)
              && (credit_q >= price);
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        stock_d       = stock_q;
        dispense_d    = 1'b0;
        item_out_d    = 2'd0;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        load          = 1'b0;
        coin_ok       = 1'b0;
        for (int i = 0; i < 3; i++)
            sold_out_d[i] = (stock_q[i] == '0);

        unique case (state_q)
            IDLE, COLLECT: begin
                if (bus.cancel && state_q == COLLECT) begin
                    state_d = PAYOUT;
                    load    = 1'b1;
                end else if (bus.sel_valid && !bus.cancel && sel_ok) begin
                    state_d    = DISPENSE;
                    dispense_d = 1'b1;
                    item_out_d = bus.item_sel;
                    credit_d   = credit_q - price;
                    for (int i = 0; i < 3; i++)
                        if (bus.item_sel == 2'(i))
                            stock_d[i] = stock_q[i] - STOCK_W'(1);
                end else begin
                    coin_ok   = 1'b1;
                    sel_err_d = bus.sel_valid && !bus.cancel;
                end
                if (state_q == IDLE && bus.restock) begin
                    stock_d    = {3{STOCK_W'(STOCK_INIT)}};
                    sold_out_d = '0;
                end
            end
            DISPENSE: begin
                load    = (credit_q != '0);
                state_d = load ? PAYOUT : IDLE;
            end
            PAYOUT: begin
                if (fire) credit_d = credit_q - 3'd1;
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Coins are only credited when nothing else claimed this cycle.
        if (coin_any) begin
            if (coin_ok && coin_sum <= 4'(MAX_CREDIT)) begin
                credit_d = coin_sum[2:0];
                state_d  = COLLECT;
            end else begin
                coin_reject_d = 1'b1;
            end
        end

        busy_d = (state_d == DISPENSE) || (state_d == PAYOUT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            stock_q       <= {3{STOCK_W'(STOCK_INIT)}};
            sold_out_q    <= '0;
            dispense_q    <= 1'b0;
            item_out_q    <= 2'd0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            stock_q       <= stock_d;
            sold_out_q    <= sold_out_d;
            dispense_q    <= dispense_d;
            item_out_q    <= item_out_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
            busy_q        <= busy_d;
        end
    end

    vend_change_pulser #(.CW(3)) u_pulser (
        .clk        (clock),
        .rst_n      (reset),
        .load       (load),
        .load_cnt   (credit_q),
        .nickel_out (nickel_out),
        .fire       (fire),
        .done       (done)
    );

    assign bus.dispense    = dispense_q;
    assign bus.item_out    = item_out_q;
    assign bus.nickel_out  = nickel_out;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sel_err     = sel_err_q;
    assign bus.credit      = credit_q;
    assign bus.sold_out    = sold_out_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Random and directed stimulus against a transaction-level model;
// expected output pulses are queued with their due cycle.
module tb_vend_controller;
    import vend_pkg::*;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    vend_if bus ();

    vend_controller dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t q_disp[$];
    ev_t q_nick[$];
    ev_t q_rej[$];
    ev_t q_err[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    int m_credit;
    int m_stock[4];
    int busy_until;

    always @(posedge clock) cyc++;

    function automatic int mprice(input int i);
        case (i)
            0:       return 3;
            1:       return 4;
            default: return 5;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q_disp.size();
            1:       return q_nick.size();
            2:       return q_rej.size();
            default: return q_err.size();
        endcase
    endfunction

    function automatic ev_t qpop(input int k);
        case (k)
            0:       return q_disp.pop_front();
            1:       return q_nick.pop_front();
            2:       return q_rej.pop_front();
            default: return q_err.pop_front();
        endcase
    endfunction

    function automatic int qdue(input int k);
        case (k)
            0:       return q_disp[0].cyc;
            1:       return q_nick[0].cyc;
            2:       return q_rej[0].cyc;
            default: return q_err[0].cyc;
        endcase
    endfunction

    function automatic void push(input int k, input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        case (k)
            0:       q_disp.push_back(e);
            1:       q_nick.push_back(e);
            2:       q_rej.push_back(e);
            default: q_err.push_back(e);
        endcase
    endfunction

    task automatic watch(input int k, input logic seen, input int val,
                         input string name);
        ev_t e;
        if (seen) begin
            n_checks++;
            if (qsize(k) == 0) begin
                n_fail++;
                $display("FAIL %s: unexpected pulse at cycle %0d, none pending",
                         name, cyc);
            end else begin
                n_checks--;
                e = qpop(k);
                check({name, " cycle"}, cyc, e.cyc);
                check({name, " value"}, val, e.val);
            end
        end else if (qsize(k) > 0 && qdue(k) <= cyc) begin
            e = qpop(k);
            n_checks++;
            n_fail++;
            $display("FAIL %s: pulse due cycle %0d not seen, now %0d",
                     name, e.cyc, cyc);
        end
    endtask

    always @(negedge clock) begin
        watch(0, bus.dispense, int'(bus.item_out), "dispense");
        watch(1, bus.nickel_out, 0, "nickel_out");
        watch(2, bus.coin_reject, 0, "coin_reject");
        watch(3, bus.sel_err, 0, "sel_err");
    end

    task automatic model_reset();
        m_credit   = 0;
        busy_until = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 4;
    endtask

    // Outcome of the inputs sampled at clock edge k.
    task automatic model_edge(input logic n, d, s, input logic [1:0] it,
                              input logic c, r, input int k);
        int  v, ch, idx;
        bit  idle_pre;
        v   = int'(n) + 2 * int'(d);
        idx = int'(it);
        if (k <= busy_until) begin
            if (v > 0) push(2, k, 0);
            return;
        end
        idle_pre = (m_credit == 0);
        if (c && m_credit > 0) begin
            for (int j = 0; j < m_credit; j++) push(1, k + 1 + 2 * j, 0);
            busy_until = k + 2 * m_credit;
            m_credit   = 0;
            if (v > 0) push(2, k, 0);
        end else if (s && !c && idx != 3 && m_stock[idx] > 0
                     && m_credit >= mprice(idx)) begin
            ch = m_credit - mprice(idx);
            push(0, k, idx);
            for (int j = 0; j < ch; j++) push(1, k + 2 + 2 * j, 0);
            busy_until = k + 2 * ch + 1;
            m_stock[idx]--;
            m_credit = 0;
            if (v > 0) push(2, k, 0);
        end else begin
            if (s && !c) push(3, k, 0);
            if (v > 0) begin
                if (m_credit + v <= 6) m_credit += v;
                else push(2, k, 0);
            end
        end
        if (r && idle_pre)
            for (int i = 0; i < 3; i++) m_stock[i] = 4;
    endtask

    task automatic check_state();
        logic [2:0] exp_so;
        check("busy", int'(bus.busy), int'(cyc < busy_until));
        if (cyc >= busy_until) begin
            for (int i = 0; i < 3; i++) exp_so[i] = (m_stock[i] == 0);
            check("credit", int'(bus.credit), m_credit);
            check("sold_out", int'(bus.sold_out), int'(exp_so));
        end
    endtask

    task automatic step(input logic n, d, s, input logic [1:0] it,
                        input logic c, r);
        @(negedge clock);
        check_state();
        bus.nickel_in = n;
        bus.dime_in   = d;
        bus.sel_valid = s;
        bus.item_sel  = it;
        bus.cancel    = c;
        bus.restock   = r;
        model_edge(n, d, s, it, c, r, cyc + 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 2'd0, 0, 0);
            if (cyc >= busy_until + 2) break;
        end
    endtask

    task automatic buy(input logic [1:0] it);
        step(0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 1, it, 0, 0);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kc;
        logic n, d, s, c, r;
        logic [1:0] it;

        bus.nickel_in = 0;
        bus.dime_in   = 0;
        bus.sel_valid = 0;
        bus.item_sel  = 0;
        bus.cancel    = 0;
        bus.restock   = 0;
        model_reset();

        repeat (3) @(negedge clock);
        check("reset dispense", int'(bus.dispense), 0);
        check("reset nickel_out", int'(bus.nickel_out), 0);
        check("reset credit", int'(bus.credit), 0);
        check("reset sold_out", int'(bus.sold_out), 0);
        check("reset busy", int'(bus.busy), 0);
        rst_n = 1'b1;

        step(1, 0, 0, 2'd0, 0, 0);
        step(0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 1, 2'd0, 0, 0);
        drain();

        buy(2'd0);

        repeat (3) step(0, 1, 0, 2'd0, 0, 0);
        step(1, 0, 0, 2'd0, 0, 0);
        step(0, 0, 0, 2'd0, 1, 0);
        drain();

        step(0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 1, 2'd2, 0, 0);
        step(0, 0, 0, 2'd0, 1, 0);
        drain();

        for (int b = 0; b < 4; b++) buy(2'd1);
        check("sold_out after 4 buys", int'(bus.sold_out), 3'b010);
        buy(2'd1);
        step(0, 0, 0, 2'd0, 1, 0);
        drain();
        step(0, 0, 0, 2'd0, 0, 1);
        drain();
        check("sold_out after restock", int'(bus.sold_out), 0);
        buy(2'd1);

        for (int i = 0; i < 2500; i++) begin
            n  = ($urandom_range(0, 99) < 30);
            d  = ($urandom_range(0, 99) < 30);
            s  = ($urandom_range(0, 99) < 15);
            c  = ($urandom_range(0, 99) < 6);
            r  = ($urandom_range(0, 99) < 2);
            it = 2'($urandom_range(0, 3));
            step(n, d, s, it, c, r);
        end
        drain();

        step(0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 2'd0, 0, 0);
        step(1, 0, 0, 2'd0, 0, 0);
        step(0, 0, 1, 2'd0, 1, 0);
        kc = cyc + 1;
        step(0, 0, 0, 2'd0, 0, 0);
        step(0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 0, 2'd0, 0, 0);
        @(negedge clock);
        check("second refund pulse cycle", cyc, kc + 3);
        #1 rst_n = 1'b0;
        #1;
        check("async reset dispense", int'(bus.dispense), 0);
        check("async reset item_out", int'(bus.item_out), 0);
        check("async reset nickel_out", int'(bus.nickel_out), 0);
        check("async reset coin_reject", int'(bus.coin_reject), 0);
        check("async reset sel_err", int'(bus.sel_err), 0);
        check("async reset credit", int'(bus.credit), 0);
        check("async reset sold_out", int'(bus.sold_out), 0);
        check("async reset busy", int'(bus.busy), 0);
        q_disp.delete();
        q_nick.delete();
        q_rej.delete();
        q_err.delete();
        model_reset();
        repeat (4) @(negedge clock);
        rst_n = 1'b1;
        repeat (6) step(0, 0, 0, 2'd0, 0, 0);

        check("pending events", q_disp.size() + q_nick.size()
              + q_rej.size() + q_err.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
